// File: rtl/mem_stage_if.sv
// Data-SRAM request/response channel between the memory stage and the SRAM.
// Handshake: the stage holds data_req with a stable address and write fields
// until the SRAM returns data_addr_ok in the same cycle; the SRAM then answers
// with exactly one data_data_ok pulse (carrying data_rdata for reads) at least
// one cycle after the accepting edge.
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds the instruction coming from Execute, runs one
// data-SRAM access for loads/stores, extends load data and produces the bus
// to writeback. A flushed access that is still in flight is drained so its
// late response cannot be mistaken for the next instruction's data.
module mem_stage #(
  parameter int HILO_W = 66
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [5:0]        stall,
  input  logic              e_valid,
  input  logic [31:0]       e_pc,
  input  logic              e_rf_we,
  input  logic [4:0]        e_rf_waddr,
  input  logic [31:0]       e_alu_res,
  input  logic [HILO_W-1:0] e_hilo_bus,
  input  logic [2:0]        e_mem_op,
  input  logic [1:0]        e_st_size,
  input  logic [31:0]       e_st_data,
  input  logic [37:0]       e_cp0_bus,
  mem_stage_if.master       sram,
  output logic              stallreq_mem,
  output logic [HILO_W+69:0] M_W_bus,
  output logic [37:0]       m_cp0_bus,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_ST   = 3'd6;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       alu_res;
    logic [HILO_W-1:0] hilo_bus;
    logic [2:0]        mem_op;
    logic [1:0]        st_size;
    logic [31:0]       st_data;
    logic [37:0]       cp0_bus;
  } in_reg_t;

  in_reg_t     r;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] ld_data;
  logic        ld_capture;
  logic        mem_act;
  logic        is_store;
  logic        is_load;
  logic        reg_update;
  logic        req;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] rf_wdata;
  logic        rf_we_eff;
  logic        unused_stall;

  // Only this stage's and writeback's stall bits matter here.
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  assign mem_act  = r.valid && (r.mem_op != OP_NONE);
  assign is_store = (r.mem_op == OP_ST);
  assign is_load  = (r.mem_op >= OP_LB) && (r.mem_op <= OP_LW);
  // Any change of the input register (capture, bubble or flush) retires DONE.
  assign reg_update = flush | ~stall[2] | ~stall[3];

  // Input register: flush/bubble clear, capture when this stage runs, else hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r <= '0;
    end else if (flush || (stall[2] && !stall[3])) begin
      r <= '0;
    end else if (!stall[2]) begin
      r.valid    <= e_valid;
      r.pc       <= e_pc;
      r.rf_we    <= e_rf_we;
      r.rf_waddr <= e_rf_waddr;
      r.alu_res  <= e_alu_res;
      r.hilo_bus <= e_hilo_bus;
      r.mem_op   <= e_mem_op;
      r.st_size  <= e_st_size;
      r.st_data  <= e_st_data;
      r.cp0_bus  <= e_cp0_bus;
    end
  end

  // Access FSM next-state; data_data_ok is only looked at in WAIT and DRAIN.
  always_comb begin
    state_nxt  = state;
    ld_capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && sram.data_addr_ok) begin
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A response arriving with the flush is already absorbed: no drain.
          state_nxt = sram.data_data_ok ? S_IDLE : S_DRAIN;
        end else if (sram.data_data_ok) begin
          state_nxt  = S_DONE;
          ld_capture = 1'b1;
        end
      end
      S_DONE: begin
        if (reg_update) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (sram.data_data_ok) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load-data register, written only by a response that belongs to us.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_data <= '0;
    end else if (ld_capture) begin
      ld_data <= sram.data_rdata;
    end
  end

  // Store byte-lane strobes and lane-replicated write data.
  always_comb begin
    wstrb = 4'b0000;
    wdata = r.st_data;
    if (is_store) begin
      case (r.st_size)
        2'd0: begin
          wstrb = 4'b0001 << r.alu_res[1:0];
          wdata = {4{r.st_data[7:0]}};
        end
        2'd1: begin
          wstrb = r.alu_res[1] ? 4'b1100 : 4'b0011;
          wdata = {2{r.st_data[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  assign req             = (state == S_IDLE) && mem_act;
  assign sram.data_req   = req;
  assign sram.data_wr    = req && is_store;
  assign sram.data_addr  = r.alu_res;
  assign sram.data_wstrb = wstrb;
  assign sram.data_wdata = wdata;

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (r.alu_res[1:0])
      2'd0:    ld_byte = ld_data[7:0];
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      default: ld_byte = ld_data[31:24];
    endcase
    ld_half = r.alu_res[1] ? ld_data[31:16] : ld_data[15:0];
    case (r.mem_op)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  assign rf_wdata  = is_load ? ld_ext : r.alu_res;
  assign rf_we_eff = r.rf_we & ~is_store;

  assign stallreq_mem = (mem_act && (state != S_DONE)) || (state == S_DRAIN);
  assign M_W_bus      = stallreq_mem ? '0 : {r.hilo_bus, r.pc, rf_we_eff, r.rf_waddr, rf_wdata};
  assign m_cp0_bus    = stallreq_mem ? '0 : r.cp0_bus;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized accesses,
// checked against a behavioural model of load extension and store lanes.
module tb_mem_stage;
  localparam int HILO_W = 66;
  localparam int BW = HILO_W + 70;
  localparam logic [5:0] RUN    = 6'b000000;
  localparam logic [5:0] HOLD   = 6'b001111;
  localparam logic [5:0] BUBBLE = 6'b000111;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic [5:0]        stall;
  logic              e_valid;
  logic [31:0]       e_pc;
  logic              e_rf_we;
  logic [4:0]        e_rf_waddr;
  logic [31:0]       e_alu_res;
  logic [HILO_W-1:0] e_hilo_bus;
  logic [2:0]        e_mem_op;
  logic [1:0]        e_st_size;
  logic [31:0]       e_st_data;
  logic [37:0]       e_cp0_bus;
  logic              stallreq_mem;
  logic [BW-1:0]     M_W_bus;
  logic [37:0]       m_cp0_bus;
  logic [1:0]        state_dbg;

  mem_stage_if sram ();

  int tests = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  // Clock generation.
  always #5 clk = ~clk;

  mem_stage #(.HILO_W(HILO_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .stall        (stall),
    .e_valid      (e_valid),
    .e_pc         (e_pc),
    .e_rf_we      (e_rf_we),
    .e_rf_waddr   (e_rf_waddr),
    .e_alu_res    (e_alu_res),
    .e_hilo_bus   (e_hilo_bus),
    .e_mem_op     (e_mem_op),
    .e_st_size    (e_st_size),
    .e_st_data    (e_st_data),
    .e_cp0_bus    (e_cp0_bus),
    .sram         (sram),
    .stallreq_mem (stallreq_mem),
    .M_W_bus      (M_W_bus),
    .m_cp0_bus    (m_cp0_bus),
    .state_dbg    (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_e();
    e_valid = 1'b0; e_pc = '0; e_rf_we = 1'b0; e_rf_waddr = '0; e_alu_res = '0;
    e_hilo_bus = '0; e_mem_op = '0; e_st_size = '0; e_st_data = '0; e_cp0_bus = '0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [1:0] size, input logic [31:0] res,
                           input logic [31:0] sdata, input logic we, input logic [4:0] waddr,
                           input logic [31:0] pc, input logic [HILO_W-1:0] hilo, input logic [37:0] cp0);
    e_valid = 1'b1; e_mem_op = op; e_st_size = size; e_alu_res = res; e_st_data = sdata;
    e_rf_we = we; e_rf_waddr = waddr; e_pc = pc; e_hilo_bus = hilo; e_cp0_bus = cp0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << addr[1:0]);
    if (size == 2'd1) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] sdata);
    if (size == 2'd0) return (sdata & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (sdata & 32'hFFFF) * 32'h00010001;
    return sdata;
  endfunction

  function automatic logic [BW-1:0] wb_word(input logic [HILO_W-1:0] hilo, input logic [31:0] pc,
                                            input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    return {hilo, pc, we, waddr, wdata};
  endfunction

  // One complete load/store: capture, request with addr_wait refused cycles,
  // data_wait response-less WAIT cycles, DONE, then release.
  task automatic do_mem_access(input string tag, input logic [2:0] op, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                               input int addr_wait, input int data_wait);
    logic [31:0]       pc;
    logic [4:0]        waddr;
    logic [HILO_W-1:0] hilo;
    logic [37:0]       cp0;
    logic              st;
    logic [BW-1:0]     exp_wb;
    pc    = $urandom();
    waddr = 5'($urandom_range(1, 31));
    hilo  = {2'($urandom()), $urandom(), $urandom()};
    cp0   = {6'($urandom()), $urandom()};
    st    = (op == 3'd6);
    exp_q.push_back(wb_word(hilo, pc, !st, waddr, st ? addr : model_load(op, addr, rdata)));
    set_instr(op, size, addr, sdata, 1'b1, waddr, pc, hilo, cp0);
    stall = RUN;
    @(negedge clk);
    clear_e();
    stall = HOLD;
    for (int i = 0; i <= addr_wait; i++) begin
      tests++; if (sram.data_req !== 1'b1) begin errors++; $display("FAIL %s req: got %b expected 1", tag, sram.data_req); end
      tests++; if (sram.data_wr !== st) begin errors++; $display("FAIL %s wr: got %b expected %b", tag, sram.data_wr, st); end
      tests++; if (sram.data_addr !== addr) begin errors++; $display("FAIL %s addr: got %h expected %h", tag, sram.data_addr, addr); end
      tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL %s stall_req: got %b expected 1", tag, stallreq_mem); end
      tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL %s bubble_req: got %h expected 0", tag, M_W_bus); end
      if (st) begin
        tests++; if (sram.data_wstrb !== model_strb(size, addr)) begin errors++; $display("FAIL %s wstrb: got %b expected %b", tag, sram.data_wstrb, model_strb(size, addr)); end
        tests++; if (sram.data_wdata !== model_wdata(size, sdata)) begin errors++; $display("FAIL %s wdata: got %h expected %h", tag, sram.data_wdata, model_wdata(size, sdata)); end
      end
      if (i == addr_wait) begin
        sram.data_addr_ok = 1'b1;
        sram.data_data_ok = 1'($urandom_range(0, 1));  // must be ignored
        sram.data_rdata   = ~rdata;
      end
      @(negedge clk);
      sram.data_addr_ok = 1'b0;
      sram.data_data_ok = 1'b0;
    end
    for (int i = 0; i <= data_wait; i++) begin
      tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL %s wait_req: got %b expected 0", tag, sram.data_req); end
      tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL %s wait_stall: got %b expected 1", tag, stallreq_mem); end
      tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL %s wait_bubble: got %h expected 0", tag, M_W_bus); end
      if (i == data_wait) begin
        sram.data_data_ok = 1'b1;
        sram.data_rdata   = rdata;
      end
      @(negedge clk);
      sram.data_data_ok = 1'b0;
      sram.data_rdata   = $urandom();
    end
    exp_wb = exp_q.pop_front();
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL %s done_stall: got %b expected 0", tag, stallreq_mem); end
    tests++; if (M_W_bus !== exp_wb) begin errors++; $display("FAIL %s wb: got %h expected %h", tag, M_W_bus, exp_wb); end
    tests++; if (m_cp0_bus !== cp0) begin errors++; $display("FAIL %s cp0: got %h expected %h", tag, m_cp0_bus, cp0); end
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL %s done_req: got %b expected 0", tag, sram.data_req); end
    clear_e();
    stall = RUN;
    @(negedge clk);
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL %s after_wb: got %h expected 0", tag, M_W_bus); end
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL %s after_stall: got %b expected 0", tag, stallreq_mem); end
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL %s after_req: got %b expected 0", tag, sram.data_req); end
  endtask

  // Non-memory instruction: visible on the writeback bus the cycle after capture.
  task automatic do_alu(input string tag, input logic [31:0] res);
    logic [31:0]       pc;
    logic [4:0]        waddr;
    logic [HILO_W-1:0] hilo;
    logic [37:0]       cp0;
    logic [BW-1:0]     exp_wb;
    pc = $urandom(); waddr = 5'($urandom_range(1, 31));
    hilo = {2'($urandom()), $urandom(), $urandom()}; cp0 = {6'($urandom()), $urandom()};
    exp_wb = wb_word(hilo, pc, 1'b1, waddr, res);
    set_instr(3'd0, 2'd0, res, $urandom(), 1'b1, waddr, pc, hilo, cp0);
    stall = RUN;
    @(negedge clk);
    clear_e();
    tests++; if (M_W_bus !== exp_wb) begin errors++; $display("FAIL %s wb: got %h expected %h", tag, M_W_bus, exp_wb); end
    tests++; if (m_cp0_bus !== cp0) begin errors++; $display("FAIL %s cp0: got %h expected %h", tag, m_cp0_bus, cp0); end
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL %s req: got %b expected 0", tag, sram.data_req); end
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL %s stall_req: got %b expected 0", tag, stallreq_mem); end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; stall = RUN;
    sram.data_addr_ok = 1'b0; sram.data_data_ok = 1'b0; sram.data_rdata = '0;
    set_instr(3'd5, 2'd2, 32'h1000, 32'h0, 1'b1, 5'd3, 32'hBFC0_0000, '1, '1);
    repeat (3) @(negedge clk);
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL reset req: got %b expected 0", sram.data_req); end
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL reset stall_req: got %b expected 0", stallreq_mem); end
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL reset wb: got %h expected 0", M_W_bus); end
    tests++; if (m_cp0_bus !== '0) begin errors++; $display("FAIL reset cp0: got %h expected 0", m_cp0_bus); end
    clear_e();
    resetn = 1'b1;
    @(negedge clk);
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL reset_release wb: got %h expected 0", M_W_bus); end
  endtask

  task automatic test_alu();
    do_alu("alu_add", 32'h5);
  endtask

  task automatic test_lw();
    do_mem_access("lw", 3'd5, 2'd2, 32'h1000, 32'h0, 32'h89AB_CDEF, 0, 1);
  endtask

  task automatic test_lb_lbu();
    do_mem_access("lb", 3'd1, 2'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0);
    do_mem_access("lbu", 3'd2, 2'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 1, 2);
  endtask

  task automatic test_sh();
    do_mem_access("sh", 3'd6, 2'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 1);
  endtask

  task automatic test_bubble();
    logic [BW-1:0] exp_wb;
    exp_wb = wb_word('0, 32'h0000_0400, 1'b1, 5'd7, 32'h1234_5678);
    set_instr(3'd0, 2'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd7, 32'h0000_0400, '0, '0);
    stall = RUN;
    @(negedge clk);
    clear_e();
    stall = HOLD;
    @(negedge clk);
    tests++; if (M_W_bus !== exp_wb) begin errors++; $display("FAIL bubble hold: got %h expected %h", M_W_bus, exp_wb); end
    stall = BUBBLE;
    @(negedge clk);
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL bubble load: got %h expected 0", M_W_bus); end
    set_instr(3'd0, 2'd0, 32'hCAFE_0001, 32'h0, 1'b1, 5'd9, 32'h0000_0500, '0, 38'h1);
    stall = RUN;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_e();
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL bubble flush_wb: got %h expected 0", M_W_bus); end
    tests++; if (m_cp0_bus !== '0) begin errors++; $display("FAIL bubble flush_cp0: got %h expected 0", m_cp0_bus); end
  endtask

  task automatic test_flush_wait();
    set_instr(3'd5, 2'd2, 32'h3000, 32'h0, 1'b1, 5'd4, 32'h0000_0600, '0, '0);
    stall = RUN;
    @(negedge clk);
    clear_e();
    stall = HOLD;
    sram.data_addr_ok = 1'b1;
    @(negedge clk);
    sram.data_addr_ok = 1'b0;
    flush = 1'b1;
    tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL flush_wait wait_stall: got %b expected 1", stallreq_mem); end
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL flush_wait drain_stall%0d: got %b expected 1", k, stallreq_mem); end
      tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL flush_wait drain_req%0d: got %b expected 0", k, sram.data_req); end
      tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL flush_wait drain_wb%0d: got %h expected 0", k, M_W_bus); end
      if (k == 2) begin
        sram.data_data_ok = 1'b1;
        sram.data_rdata   = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      sram.data_data_ok = 1'b0;
    end
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL flush_wait end_stall: got %b expected 0", stallreq_mem); end
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL flush_wait end_wb: got %h expected 0", M_W_bus); end
    do_mem_access("flush_wait_next", 3'd5, 2'd2, 32'h3004, 32'h0, 32'h0BAD_F00D, 0, 0);
  endtask

  task automatic test_flush_idle();
    set_instr(3'd3, 2'd1, 32'h4002, 32'h0, 1'b1, 5'd5, 32'h0000_0700, '0, '0);
    stall = RUN;
    @(negedge clk);
    clear_e();
    stall = HOLD;
    tests++; if (sram.data_req !== 1'b1) begin errors++; $display("FAIL flush_idle req: got %b expected 1", sram.data_req); end
    sram.data_addr_ok = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    sram.data_addr_ok = 1'b0;
    flush = 1'b0;
    tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL flush_idle drain_stall: got %b expected 1", stallreq_mem); end
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL flush_idle drain_req: got %b expected 0", sram.data_req); end
    @(negedge clk);
    tests++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL flush_idle drain_stall2: got %b expected 1", stallreq_mem); end
    sram.data_data_ok = 1'b1;
    sram.data_rdata   = 32'h1111_2222;
    @(negedge clk);
    sram.data_data_ok = 1'b0;
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL flush_idle end_stall: got %b expected 0", stallreq_mem); end
    do_mem_access("flush_idle_next", 3'd4, 2'd1, 32'h4002, 32'h0, 32'h8765_4321, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    set_instr(3'd5, 2'd2, 32'h5000, 32'h0, 1'b1, 5'd6, 32'h0000_0800, '1, '1);
    stall = RUN;
    @(negedge clk);
    clear_e();
    stall = HOLD;
    sram.data_addr_ok = 1'b1;
    @(negedge clk);
    sram.data_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    tests++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL rst_wait stall_req: got %b expected 0", stallreq_mem); end
    tests++; if (sram.data_req !== 1'b0) begin errors++; $display("FAIL rst_wait req: got %b expected 0", sram.data_req); end
    tests++; if (M_W_bus !== '0) begin errors++; $display("FAIL rst_wait wb: got %h expected 0", M_W_bus); end
    tests++; if (m_cp0_bus !== '0) begin errors++; $display("FAIL rst_wait cp0: got %h expected 0", m_cp0_bus); end
    @(negedge clk);
    resetn = 1'b1;
    stall  = RUN;
    @(negedge clk);
    do_mem_access("rst_wait_next", 3'd5, 2'd2, 32'h5000, 32'h0, 32'h2468_ACE0, 0, 1);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom_range(0, 6));
      size = 2'($urandom_range(0, 2));
      addr = $urandom();
      if (op == 3'd0) begin
        do_alu("rand_alu", $urandom());
      end else begin
        do_mem_access("rand_mem", op, size, addr, $urandom(), $urandom(),
                      $urandom_range(0, 2), $urandom_range(0, 2));
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    clear_e();
    test_reset();
    test_alu();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_bubble();
    test_flush_wait();
    test_flush_idle();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter HILO_W, 66, width of the HI/LO write bus carried through to writeback.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  from CTRL; discards the instruction held in this stage.
REQ-005 stall  in  6  from CTRL; bit 2 = this stage, bit 3 = writeback stage.
REQ-006 e_valid, e_pc[31:0], e_rf_we, e_rf_waddr[4:0], e_alu_res[31:0], e_hilo_bus[HILO_W-1:0]  in  -  Execute results.
REQ-007 e_mem_op  in  3  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB/SH/SW (selected by e_st_size[1:0]: 0=B, 1=H, 2=W).
REQ-008 e_st_data  in  32  store data; e_cp0_bus  in  38  CP0 write bus.
REQ-009 data_req, data_wr, data_addr[31:0], data_wstrb[3:0], data_wdata[31:0]  out  -  data-SRAM request.
REQ-010 data_addr_ok, data_data_ok  in  1  SRAM accept / response strobes; data_rdata  in  32.
REQ-011 stallreq_mem  out  1  to CTRL; holds the pipeline while an access is pending.
REQ-012 M_W_bus  out  HILO_W+70  {hilo_bus, pc, rf_we, rf_waddr, rf_wdata}; m_cp0_bus  out  38.

Function
REQ-013 The input register SHALL clear on flush; load a bubble when stall[2]=1 and stall[3]=0; capture Execute inputs when stall[2]=0; and otherwise hold.
REQ-014 The FSM SHALL have four states: IDLE, WAIT, DONE and DRAIN.
REQ-015 In IDLE, with a valid mem_op != 0, data_req SHALL be 1; data_addr = alu_res; data_wr = 1 for stores only.
REQ-016 IDLE SHALL move to WAIT on data_addr_ok.
REQ-017 In WAIT, data_req SHALL be 0; on data_data_ok the FSM SHALL capture data_rdata and move to DONE.
REQ-018 DONE SHALL return to IDLE when the input register captures a new instruction or is flushed.
REQ-019 stallreq_mem SHALL be 1 when a valid mem_op != 0 is present and state != DONE, or when state = DRAIN.
REQ-020 data_data_ok SHALL be ignored in the same cycle as data_addr_ok; the SRAM guarantees response latency >= 1 cycle.
REQ-021 A flush in WAIT SHALL move the FSM to DRAIN; DRAIN SHALL absorb the next data_data_ok without using the data and then return to IDLE.
REQ-022 A flush in IDLE while data_req=1 and data_addr_ok=1 SHALL also move the FSM to DRAIN.
REQ-023 Store strobes: SB gives wstrb = 1<<addr[1:0] with wdata = 4 copies of byte[7:0]; SH gives wstrb = 0011 or 1100 by addr[1] with wdata = 2 copies of half[15:0]; SW gives wstrb = 1111.
REQ-024 Loads SHALL select the byte by addr[1:0] and the halfword by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes all 32 bits.
REQ-025 Alignment SHALL NOT be checked in this stage; Execute raises address exceptions.
REQ-026 rf_wdata SHALL be the extended load data for loads and alu_res for all other ops.
REQ-027 M_W_bus and m_cp0_bus SHALL be combinational from the input register and the load-data register, and SHALL carry an all-zero bubble while stallreq_mem=1.
REQ-028 Stores SHALL write back nothing (rf_we forced 0); DONE SHALL be reached on data_data_ok.

Reset
REQ-029 While resetn=0: state = IDLE, input register = 0, load-data register = 0, data_req = 0, stallreq_mem = 0, M_W_bus = 0, m_cp0_bus = 0.
REQ-030 Reset mid-WAIT SHALL abandon the transaction; the SRAM model is reset together with this stage.
REQ-031 The first request SHALL be issued no earlier than the first rising edge after resetn deasserts.

Verification
REQ-032 LW at addr 0x1000, addr_ok in cycle 0, data_ok=1 with rdata=0x89ABCDEF in cycle 2 -> stallreq_mem high for cycles 0-2; M_W_bus rf_wdata=0x89ABCDEF, rf_we=1 in cycle 3.
REQ-033 LB at addr 0x1003, rdata=0x80FFFFFF -> rf_wdata=0xFFFFFF80; LBU at the same addr -> 0x00000080.
REQ-034 SH at addr 0x2002, st_data=0x0000BEEF -> data_wstrb=1100, data_wdata=0xBEEFBEEF, data_wr=1, rf_we=0 at writeback.
REQ-035 Flush while in WAIT, data_ok 3 cycles later -> stallreq_mem stays 1 until data_ok; the returned data never appears on M_W_bus; FSM back in IDLE.
REQ-036 Non-memory ADD result 0x5, no stall -> M_W_bus shows rf_wdata=0x5 the cycle after capture; data_req stays 0.
REQ-037 resetn pulsed low during WAIT -> all outputs 0 immediately (asynchronously); next LW proceeds normally.
